// File: rtl/stage_sequencer_if.sv
// Handshake and status bundle between the stage sequencer and the
// LEGv8 datapath / memories. The sequencer uses the master view.
interface stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             halt_req;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             reg_read_en;
    logic             exec_en;
    logic             dmem_req;
    logic             reg_write_en;
    logic             pc_write_en;
    logic [2:0]       stage;
    logic             busy;
    logic             done;
    logic             error;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  start, halt_req, mem_read, mem_write, reg_write, imem_ready, dmem_ready,
        output imem_req, reg_read_en, exec_en, dmem_req, reg_write_en, pc_write_en,
        output stage, busy, done, error, cycle_count, retired_count
    );

    modport slave (
        output start, halt_req, mem_read, mem_write, reg_write, imem_ready, dmem_ready,
        input  imem_req, reg_read_en, exec_en, dmem_req, reg_write_en, pc_write_en,
        input  stage, busy, done, error, cycle_count, retired_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Moore FSM that steps the nonpipelined LEGv8 datapath through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with one-hot stage enables,
// waits on multi-cycle memories with a timeout, and keeps saturating
// busy-cycle and retired-instruction counters.
module stage_sequencer #(
    parameter int MAX_INSTR = 0,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    stage_sequencer_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 2);
    // Last wait count before the stall is declared a timeout.
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  INSTR_LIMIT = CNT_W'(MAX_INSTR);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } stage_t;

    stage_t             state_r;
    stage_t             next_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [CNT_W-1:0]   cycle_cnt_r;
    logic [CNT_W-1:0]   retired_cnt_r;
    logic [CNT_W-1:0]   retired_inc_s;
    logic               ready_s;
    logic               waiting_s;
    logic               wait_expired_s;
    logic               limit_hit_s;
    logic               error_r;
    logic               imem_req_r;
    logic               reg_read_en_r;
    logic               exec_en_r;
    logic               dmem_req_r;
    logic               reg_write_en_r;
    logic               pc_write_en_r;
    logic               busy_r;
    logic               done_r;

    // Stall detection, timeout and retire-limit conditions for the current stage.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_FETCH:  ready_s = bus.imem_ready;
            ST_MEMORY: ready_s = bus.dmem_ready;
            default:   ready_s = 1'b0;
        endcase
        waiting_s      = ((state_r == ST_FETCH) || (state_r == ST_MEMORY)) && !ready_s;
        wait_expired_s = waiting_s && (TIMEOUT != 0) && (wait_cnt_r == WAIT_LAST);
        if (retired_cnt_r == {CNT_W{1'b1}}) begin
            retired_inc_s = retired_cnt_r;
        end else begin
            retired_inc_s = retired_cnt_r + CNT_W'(1);
        end
        limit_hit_s = (MAX_INSTR != 0) && (retired_inc_s == INSTR_LIMIT);
    end

    // Next-stage selection.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) next_s = ST_FETCH;
                else           next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bus.imem_ready)     next_s = ST_DECODE;
                else if (wait_expired_s) next_s = ST_HALT;
                else                    next_s = ST_FETCH;
            end
            ST_DECODE:  next_s = ST_EXECUTE;
            ST_EXECUTE: begin
                if (bus.mem_read || bus.mem_write) next_s = ST_MEMORY;
                else                               next_s = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (bus.dmem_ready)      next_s = ST_WRITEBACK;
                else if (wait_expired_s) next_s = ST_HALT;
                else                     next_s = ST_MEMORY;
            end
            ST_WRITEBACK: begin
                if (bus.halt_req || limit_hit_s) next_s = ST_HALT;
                else                             next_s = ST_FETCH;
            end
            ST_HALT:  next_s = ST_HALT;
            default:  next_s = ST_IDLE;
        endcase
    end

    // Stage register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_s;
    end

    // Memory wait counter: counts stalled cycles, cleared whenever not stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= '0;
        end else if (waiting_s) begin
            if (wait_cnt_r != {WAIT_W{1'b1}}) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            else                              wait_cnt_r <= wait_cnt_r;
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Saturating busy-cycle and retire counters plus the sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_r   <= '0;
            retired_cnt_r <= '0;
            error_r       <= 1'b0;
        end else begin
            if (busy_r && (cycle_cnt_r != {CNT_W{1'b1}})) cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
            else                                           cycle_cnt_r <= cycle_cnt_r;
            if (state_r == ST_WRITEBACK) retired_cnt_r <= retired_inc_s;
            else                         retired_cnt_r <= retired_cnt_r;
            error_r <= error_r | wait_expired_s;
        end
    end

    // Stage enables registered alongside the stage so they decode the stage only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_req_r     <= 1'b0;
            reg_read_en_r  <= 1'b0;
            exec_en_r      <= 1'b0;
            dmem_req_r     <= 1'b0;
            reg_write_en_r <= 1'b0;
            pc_write_en_r  <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            imem_req_r     <= (next_s == ST_FETCH);
            reg_read_en_r  <= (next_s == ST_DECODE);
            exec_en_r      <= (next_s == ST_EXECUTE);
            dmem_req_r     <= (next_s == ST_MEMORY);
            reg_write_en_r <= (next_s == ST_WRITEBACK) && bus.reg_write;
            pc_write_en_r  <= (next_s == ST_WRITEBACK);
            busy_r         <= (next_s != ST_IDLE) && (next_s != ST_HALT);
            done_r         <= (next_s == ST_HALT);
        end
    end

    assign bus.stage         = state_r;
    assign bus.imem_req      = imem_req_r;
    assign bus.reg_read_en   = reg_read_en_r;
    assign bus.exec_en       = exec_en_r;
    assign bus.dmem_req      = dmem_req_r;
    assign bus.reg_write_en  = reg_write_en_r;
    assign bus.pc_write_en   = pc_write_en_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.error         = error_r;
    assign bus.cycle_count   = cycle_cnt_r;
    assign bus.retired_count = retired_cnt_r;
endmodule
